// File: rtl/ps2_host_tx_ctrl.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, bit shifting on
// device clock falls, ACK check and inter-edge timeout, driving open-drain enables for both lines.
module ps2_host_tx_ctrl #(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYC - 2);
  localparam logic [CNT_W-1:0] TO_PRE   = CNT_W'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE, ERR
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       bitcnt, bitcnt_nx;
  logic [9:0]       frame, frame_nx;
  logic             clk_oe_nx, data_oe_nx;
  logic [2:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             fe, clk_s, data_s;

  assign fe     = ~clk_sync[1] & clk_sync[2];
  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  assign cmd_ready  = (state == IDLE);
  assign rx_inhibit = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = (state == ERR);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bitcnt_nx  = bitcnt;
    frame_nx   = frame;
    clk_oe_nx  = ps2_clk_oe;
    data_oe_nx = ps2_data_oe;
    case (state)
      IDLE: begin
        clk_oe_nx  = 1'b0;
        data_oe_nx = 1'b0;
        if (cmd_valid) begin
          frame_nx   = {1'b1, ~^cmd_byte, cmd_byte};
          cnt_nx     = '0;
          bitcnt_nx  = '0;
          state_nx   = INHIBIT;
          clk_oe_nx  = 1'b1;
          data_oe_nx = (INHIBIT_CYC == 1);
        end
      end
      INHIBIT: begin
        cnt_nx     = cnt + CNT_W'(1);
        data_oe_nx = (cnt == INH_PRE);
        if (cnt == INH_LAST) begin
          state_nx   = REQ;
          clk_oe_nx  = 1'b0;
          data_oe_nx = 1'b1;
          cnt_nx     = '0;
        end
      end
      // Each device clock fall presents the next frame bit; the stop bit (1) releases data.
      REQ, SEND: begin
        if (fe) begin
          data_oe_nx = ~frame[0];
          frame_nx   = {1'b1, frame[9:1]};
          bitcnt_nx  = bitcnt + 4'd1;
          if (state == REQ) begin
            state_nx  = SEND;
            bitcnt_nx = 4'd1;
          end else if (bitcnt == 4'd9) begin
            state_nx = ACK;
          end
        end
      end
      ACK: begin
        data_oe_nx = 1'b0;
        if (fe) state_nx = data_s ? ERR : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      ERR: begin
        clk_oe_nx  = 1'b0;
        data_oe_nx = 1'b0;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Inter-edge watchdog; the fall that reloads it also defers the abort by one full window.
    if (state inside {REQ, SEND, ACK, WAIT_IDLE}) begin
      cnt_nx = fe ? '0 : cnt + CNT_W'(1);
      if (!fe && (cnt == TO_PRE)) begin
        state_nx   = ERR;
        clk_oe_nx  = 1'b0;
        data_oe_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bitcnt      <= '0;
      clk_sync    <= 3'b111;
      data_sync   <= 2'b11;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      bitcnt      <= bitcnt_nx;
      clk_sync    <= {clk_sync[1:0], ps2_clk_in};
      data_sync   <= {data_sync[0], ps2_data_in};
      ps2_clk_oe  <= clk_oe_nx;
      ps2_data_oe <= data_oe_nx;
    end
  end

  always_ff @(posedge clk) begin
    frame <= frame_nx;
  end

endmodule

// File: tb/tb_ps2_host_tx_ctrl.sv
// Directed bench for ps2_host_tx_ctrl with a PS/2 device model that clocks every 20 cycles
// and records the data line level just before each rising edge.
module tb_ps2_host_tx_ctrl;
  localparam int INHIBIT = 8;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       dev_clk = 1'b0;
  logic       dev_data = 1'b0;
  logic       cmd_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, done, err;
  logic       ps2_clk_in, ps2_data_in;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic err_oe = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk);
  assign ps2_data_in = ~(ps2_data_oe | dev_data);

  ps2_host_tx_ctrl #(.INHIBIT_CYC(INHIBIT), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .rx_inhibit(rx_inhibit), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      err_oe = ps2_clk_oe | ps2_data_oe;
    end
    if (done && err) both_cnt++;
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts clock-inhibit cycles after accept; returns at the first cycle with clk_oe low.
  task automatic inhibit_watch(output int hi, output int dfirst, output logic req_data);
    hi = 0;
    dfirst = -1;
    @(negedge clk);
    while (ps2_clk_oe && hi < 50) begin
      if (ps2_data_oe && dfirst < 0) dfirst = hi;
      hi++;
      @(negedge clk);
    end
    req_data = ps2_data_oe;
  endtask

  task automatic device_clock(input int nclk, input bit ack, output logic [9:0] bits);
    bits = '0;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      if (k == 11) begin
        dev_data = ack;
        repeat (5) @(negedge clk);
      end
      dev_clk = 1'b1;
      repeat (19) @(negedge clk);
      if (k <= 10) bits[k-1] = ps2_data_in;
      @(negedge clk);
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
    end
    dev_data = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) n = -1;
  endtask

  task automatic test_reset;
    checks++;
    if ({cmd_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, done, err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=100000",
               {cmd_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, done, err});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit} !== 4'b1000) begin
      failures++;
      $display("FAIL after_reset got=%b exp=1000", {cmd_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit});
    end
  endtask

  // 0xED: 6 ones -> parity 1; 0x07: 3 ones -> parity 0; 0xFF: 8 ones -> parity 1.
  task automatic test_frames;
    logic [7:0] bytes [3] = '{8'hED, 8'h07, 8'hFF};
    logic [9:0] exp   [3] = '{10'h3ED, 10'h207, 10'h3FF};
    int hi, df, n, d0, e0;
    logic rq;
    logic [9:0] bits;
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send_cmd(bytes[i]);
      inhibit_watch(hi, df, rq);
      checks++;
      if (hi !== INHIBIT) begin
        failures++;
        $display("FAIL inhibit_len[%0d] got=%0d exp=%0d", i, hi, INHIBIT);
      end
      checks++;
      if (df !== INHIBIT - 1) begin
        failures++;
        $display("FAIL data_oe_on_last_inhibit[%0d] got=%0d exp=%0d", i, df, INHIBIT - 1);
      end
      checks++;
      if ({rq, rx_inhibit, cmd_ready} !== 3'b110) begin
        failures++;
        $display("FAIL req_state[%0d] got=%b exp=110", i, {rq, rx_inhibit, cmd_ready});
      end
      device_clock(11, 1'b1, bits);
      checks++;
      if (bits !== exp[i]) begin
        failures++;
        $display("FAIL line_bits[%0d] got=%h exp=%h", i, bits, exp[i]);
      end
      wait_ready(n);
      checks++;
      if (n < 0 || done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
        failures++;
        $display("FAIL frame_done[%0d] got ready=%0d done=%0d err=%0d exp done=1 err=0",
                 i, n, done_cnt - d0, err_cnt - e0);
      end
    end
  endtask

  task automatic test_no_ack;
    int hi, df, n, d0, e0;
    logic rq;
    logic [9:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    err_oe = 1'b1;
    send_cmd(8'hFF);
    inhibit_watch(hi, df, rq);
    device_clock(11, 1'b0, bits);
    wait_ready(n);
    checks++;
    if (n < 0 || err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      failures++;
      $display("FAIL no_ack got ready=%0d err=%0d done=%0d exp err=1 done=0",
               n, err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if ({err_oe, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin
      failures++;
      $display("FAIL no_ack_lines got=%b exp=000", {err_oe, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  // The fall is driven mid-cycle; two synchroniser cycles precede detection, then 200 more.
  task automatic test_timeout;
    int hi, df, n;
    logic rq;
    logic [9:0] bits;
    send_cmd(8'h5A);
    inhibit_watch(hi, df, rq);
    device_clock(3, 1'b1, bits);
    dev_clk = 1'b1;
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 20) dev_clk = 1'b0;
    end
    checks++;
    if (n !== 202) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=202", n);
    end
    checks++;
    if ({err, done, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
      failures++;
      $display("FAIL timeout_lines got=%b exp=1000", {err, done, ps2_clk_oe, ps2_data_oe});
    end
    wait_ready(n);
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL timeout_idle got=%0d exp>=0", n);
    end
  endtask

  // 0x12 has bit5 = 0, so data is being pulled low while that bit is on the line.
  task automatic test_reset_mid;
    int hi, df;
    logic rq;
    logic [9:0] bits;
    send_cmd(8'h12);
    inhibit_watch(hi, df, rq);
    device_clock(6, 1'b1, bits);
    checks++;
    if ({ps2_data_oe, rx_inhibit} !== 2'b11) begin
      failures++;
      $display("FAIL bit5_drive got=%b exp=11", {ps2_data_oe, rx_inhibit});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, rx_inhibit, cmd_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=0001", {ps2_clk_oe, ps2_data_oe, rx_inhibit, cmd_ready});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, rx_inhibit} !== 2'b10) begin
      failures++;
      $display("FAIL after_mid_reset got=%b exp=10", {cmd_ready, rx_inhibit});
    end
  endtask

  // 0xF4: 5 ones -> parity 0.
  task automatic test_back_to_back;
    int hi1, df1, hi2, df2, n1, n2, d0, e0;
    logic rq1, rq2, busy_ready;
    logic [9:0] bits1, bits2;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_byte  = 8'hF4;
    @(posedge clk);
    #1 cmd_byte = 8'hED;
    inhibit_watch(hi1, df1, rq1);
    busy_ready = cmd_ready;
    device_clock(11, 1'b1, bits1);
    wait_ready(n1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    inhibit_watch(hi2, df2, rq2);
    device_clock(11, 1'b1, bits2);
    wait_ready(n2);
    checks++;
    if (busy_ready !== 1'b0) begin
      failures++;
      $display("FAIL busy_ready got=%b exp=0", busy_ready);
    end
    checks++;
    if (hi1 !== INHIBIT || hi2 !== INHIBIT || df2 !== INHIBIT - 1) begin
      failures++;
      $display("FAIL b2b_inhibit got=%0d,%0d,%0d exp=%0d,%0d,%0d", hi1, hi2, df2,
               INHIBIT, INHIBIT, INHIBIT - 1);
    end
    checks++;
    if (bits1 !== 10'h2F4) begin
      failures++;
      $display("FAIL b2b_frame1 got=%h exp=2f4", bits1);
    end
    checks++;
    if (bits2 !== 10'h3ED) begin
      failures++;
      $display("FAIL b2b_frame2 got=%h exp=3ed", bits2);
    end
    checks++;
    if (n1 < 0 || n2 < 0 || done_cnt - d0 != 2 || err_cnt - e0 != 0) begin
      failures++;
      $display("FAIL b2b_done got ready=%0d,%0d done=%0d err=%0d exp done=2 err=0",
               n1, n2, done_cnt - d0, err_cnt - e0);
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({cmd_ready, ps2_clk_oe} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_no_third got=%b exp=10", {cmd_ready, ps2_clk_oe});
    end
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL done_err_overlap got=%0d exp=0", both_cnt);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    test_frames;
    test_no_ack;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
